// File: rtl/sram_req_arbiter_if.sv
// SRAM-like request/response bundle shared by the core ports and the downstream port.
// master drives the request fields; slave returns the handshakes and read data.
interface sram_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// Merges the inst and data SRAM ports onto one downstream port: data-first priority with an
// inst starvation guard, and an in-order owner FIFO that routes each response to its requester.
module sram_req_arbiter #(
  parameter int OUTSTANDING  = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                reset,
  sram_req_arbiter_if.slave   inst_sram,
  sram_req_arbiter_if.slave   data_sram,
  sram_req_arbiter_if.master  mem_sram
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int SW = ($clog2(STARVE_LIMIT + 1) < 2) ? 2 : $clog2(STARVE_LIMIT + 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  localparam logic [PW:0]   FULL       = (PW + 1)'(OUTSTANDING);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

  logic [0:0]             state;
  logic                   sel;
  logic [SW-1:0]          starve;
  logic [OUTSTANDING-1:0] id_fifo;
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [PW:0]            count;

  sram_req_t [1:0] port_req;
  sram_req_t       mem_req_f;
  logic            grant;
  logic            gsel;
  logic            accept;
  logic            pop;
  logic            head;

  assign port_req[0] = {inst_sram.wr, inst_sram.size, inst_sram.wstrb,
                        inst_sram.addr, inst_sram.wdata};
  assign port_req[1] = {data_sram.wr, data_sram.size, data_sram.wstrb,
                        data_sram.addr, data_sram.wdata};

  // Grant depends only on registered state and requester inputs, never on mem addr_ok.
  always_comb begin
    grant = 1'b0;
    gsel  = sel;
    if (!reset) begin
      if (state == S_LOCKED) begin
        grant = 1'b1;
        gsel  = sel;
      end else if (count != FULL) begin
        if (data_sram.req && !(starve == STARVE_MAX && inst_sram.req)) begin
          grant = 1'b1;
          gsel  = 1'b1;
        end else if (inst_sram.req) begin
          grant = 1'b1;
          gsel  = 1'b0;
        end
      end
    end
  end

  assign accept    = grant & mem_sram.addr_ok;
  assign mem_req_f = grant ? port_req[gsel] : '0;

  assign mem_sram.req   = grant;
  assign mem_sram.wr    = mem_req_f.wr;
  assign mem_sram.size  = mem_req_f.size;
  assign mem_sram.wstrb = mem_req_f.wstrb;
  assign mem_sram.addr  = mem_req_f.addr;
  assign mem_sram.wdata = mem_req_f.wdata;

  assign inst_sram.addr_ok = accept & ~gsel;
  assign data_sram.addr_ok = accept &  gsel;

  // Responses with no recorded owner are dropped.
  assign head = id_fifo[rd_ptr];
  assign pop  = mem_sram.data_ok & (count != '0) & ~reset;

  assign inst_sram.data_ok = pop & ~head;
  assign data_sram.data_ok = pop &  head;
  assign inst_sram.rdata   = mem_sram.rdata;
  assign data_sram.rdata   = mem_sram.rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      sel     <= 1'b0;
      starve  <= '0;
      id_fifo <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) sel <= gsel;
          if (grant && !mem_sram.addr_ok) state <= S_LOCKED;
        end
        default: begin
          if (mem_sram.addr_ok) state <= S_IDLE;
        end
      endcase

      if (accept) begin
        if (gsel && inst_sram.req)
          starve <= (starve == STARVE_MAX) ? starve : starve + SW'(1);
        else
          starve <= '0;
        id_fifo[wr_ptr] <= gsel;
        wr_ptr          <= wr_ptr + PW'(1);
      end

      if (pop) rd_ptr <= rd_ptr + PW'(1);

      case ({accept, pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Random requesters and an in-order memory drive the arbiter; a queue-based reference model
// predicts every grant, handshake and response route.
module tb_sram_req_arbiter;
  localparam int OUTSTANDING  = 4;
  localparam int STARVE_LIMIT = 3;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_req_arbiter_if inst_sram();
  sram_req_arbiter_if data_sram();
  sram_req_arbiter_if mem_sram();

  sram_req_arbiter #(.OUTSTANDING(OUTSTANDING), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .inst_sram (inst_sram),
    .data_sram (data_sram),
    .mem_sram  (mem_sram)
  );

  int total = 0;
  int bad   = 0;

  // requester / memory stimulus state
  bit          ireq = 0, dreq = 0;
  req_t        ifld = '0, dfld = '0;
  logic [31:0] mem_q[$];

  // reference model state
  int owners[$];
  int lock_own = -1;
  int starve_m = 0;

  int n_iacc = 0, n_dacc = 0, n_dok = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.wr    = 1'($urandom_range(1));
    r.size  = 2'($urandom_range(3));
    r.wstrb = 4'($urandom_range(15));
    r.addr  = $urandom;
    r.wdata = $urandom;
    return r;
  endfunction

  task automatic cycle(input int pi, input int pd, input int pa, input int pr,
                       input int ps, input bit rst);
    int   eg;
    int   own;
    bit   acc, pop, mq;
    req_t ef;
    @(negedge clk);
    reset = rst;
    if (!ireq && $urandom_range(99) < pi) begin ireq = 1; ifld = rand_req(); end
    if (!dreq && $urandom_range(99) < pd) begin dreq = 1; dfld = rand_req(); end
    inst_sram.req = ireq;
    {inst_sram.wr, inst_sram.size, inst_sram.wstrb, inst_sram.addr, inst_sram.wdata} = ifld;
    data_sram.req = dreq;
    {data_sram.wr, data_sram.size, data_sram.wstrb, data_sram.addr, data_sram.wdata} = dfld;
    mem_sram.addr_ok = ($urandom_range(99) < pa);
    mq = 0;
    if (mem_q.size() > 0 && $urandom_range(99) < pr) begin
      mq = 1;
      mem_sram.data_ok = 1'b1;
      mem_sram.rdata   = mem_q[0];
    end else begin
      mem_sram.data_ok = (mem_q.size() == 0) && ($urandom_range(99) < ps);
      mem_sram.rdata   = $urandom;
    end
    #2;

    // expected grant: held selection first, then data unless inst has waited too long
    eg = -1;
    if (!rst) begin
      if (lock_own >= 0) eg = lock_own;
      else if (owners.size() < OUTSTANDING) begin
        if (dreq && !(starve_m == STARVE_LIMIT && ireq)) eg = 1;
        else if (ireq) eg = 0;
      end
    end
    acc = (eg >= 0) && mem_sram.addr_ok;
    pop = !rst && mem_sram.data_ok && owners.size() > 0;
    own = pop ? owners[0] : -1;

    chk("mem_req", 64'(mem_sram.req), 64'(eg >= 0));
    if (eg >= 0) begin
      ef = (eg == 1) ? dfld : ifld;
      chk("mem_addr", 64'(mem_sram.addr), 64'(ef.addr));
      chk("mem_ctl", 64'({mem_sram.wr, mem_sram.size, mem_sram.wstrb, mem_sram.wdata}),
          64'({ef.wr, ef.size, ef.wstrb, ef.wdata}));
    end
    if (rst) begin
      chk("rst_fld", 64'({mem_sram.wr, mem_sram.size, mem_sram.wstrb, mem_sram.addr}), 64'd0);
      chk("rst_wd", 64'(mem_sram.wdata), 64'd0);
    end
    chk("i_aok", 64'(inst_sram.addr_ok), 64'(acc && eg == 0));
    chk("d_aok", 64'(data_sram.addr_ok), 64'(acc && eg == 1));
    chk("i_dok", 64'(inst_sram.data_ok), 64'(own == 0));
    chk("d_dok", 64'(data_sram.data_ok), 64'(own == 1));
    chk("i_rd", 64'(inst_sram.rdata), 64'(mem_sram.rdata));
    chk("d_rd", 64'(data_sram.rdata), 64'(mem_sram.rdata));

    n_iacc += int'(inst_sram.addr_ok);
    n_dacc += int'(data_sram.addr_ok);
    n_dok  += int'(inst_sram.data_ok) + int'(data_sram.data_ok);

    // the memory answers whatever it accepted, regardless of the arbiter's reset
    if (mq) void'(mem_q.pop_front());
    if (rst) begin
      owners.delete();
      lock_own = -1;
      starve_m = 0;
    end else begin
      if (pop) void'(owners.pop_front());
      if (acc) begin
        owners.push_back(eg);
        mem_q.push_back($urandom);
        lock_own = -1;
        if (eg == 1) starve_m = ireq ? ((starve_m < STARVE_LIMIT) ? starve_m + 1 : STARVE_LIMIT) : 0;
        else         starve_m = 0;
        if (eg == 1) dreq = 0;
        else         ireq = 0;
      end else if (eg >= 0) begin
        lock_own = eg;
      end
    end
  endtask

  task automatic drain_and_reset();
    for (int i = 0; i < 12; i++) cycle(0, 0, 100, 100, 0, 1'b0);
    cycle(0, 0, 100, 100, 0, 1'b1);
  endtask

  int ph[5][5] = '{'{50, 50, 70, 60, 5}, '{90, 90, 30, 20, 0}, '{20, 80, 100, 50, 5},
                   '{100, 100, 50, 90, 0}, '{30, 30, 100, 100, 10}};

  initial begin
    reset = 1'b1;
    inst_sram.req = 0; inst_sram.wr = 0; inst_sram.size = 0; inst_sram.wstrb = 0;
    inst_sram.addr = 0; inst_sram.wdata = 0;
    data_sram.req = 0; data_sram.wr = 0; data_sram.size = 0; data_sram.wstrb = 0;
    data_sram.addr = 0; data_sram.wdata = 0;
    mem_sram.addr_ok = 0; mem_sram.data_ok = 0; mem_sram.rdata = 0;

    cycle(0, 0, 0, 0, 0, 1'b1);
    cycle(60, 60, 50, 0, 0, 1'b1);

    for (int p = 0; p < 5; p++)
      for (int c = 0; c < 400; c++)
        cycle(ph[p][0], ph[p][1], ph[p][2], ph[p][3], ph[p][4], $urandom_range(199) == 0);

    // both ports hammering: one inst grant after every STARVE_LIMIT data grants
    drain_and_reset();
    n_iacc = 0; n_dacc = 0;
    for (int i = 0; i < 16; i++) cycle(100, 100, 100, 100, 0, 1'b0);
    chk("starve_inst", 64'(n_iacc), 64'd4);
    chk("starve_data", 64'(n_dacc), 64'd12);

    // FIFO full: a pop does not free a slot in the same cycle
    drain_and_reset();
    n_iacc = 0; n_dacc = 0;
    for (int i = 0; i < 8; i++) cycle(0, 100, 100, 0, 0, 1'b0);
    chk("full_acc", 64'(n_dacc), 64'd4);
    cycle(0, 100, 100, 100, 0, 1'b0);
    chk("full_pop_same", 64'(n_dacc), 64'd4);
    cycle(0, 100, 100, 0, 0, 1'b0);
    chk("full_pop_next", 64'(n_dacc), 64'd5);

    // reset with IDs outstanding: later responses are dropped
    drain_and_reset();
    for (int i = 0; i < 3; i++) cycle(0, 100, 100, 0, 0, 1'b0);
    cycle(0, 0, 100, 0, 0, 1'b1);
    n_dok = 0;
    for (int i = 0; i < 6; i++) cycle(0, 0, 100, 100, 0, 1'b0);
    chk("rst_drop", 64'(n_dok), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
